// File: rtl/agc_timing_gen_pkg.sv
// Shared constants for the AGC timing generator: step modes, step-FSM states
// and default ring geometry.
package agc_timing_gen_pkg;

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_ISTEP = 2'd1;
    localparam logic [1:0] MODE_CSTEP = 2'd2;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_GO   = 2'd2
    } step_state_t;

    localparam int DEF_NUM_TP = 12;
    localparam int DEF_PHASES = 4;

endpackage

// File: rtl/agc_timing_gen_tp_ring.sv
// One-hot time-pulse rotator. Moves only on adv; force_last wins over hold,
// and reset parks the ring on the last pulse.
module agc_timing_gen_tp_ring #(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         hold,
    input  logic         force_last,
    output logic [N-1:0] t
);

    localparam logic [N-1:0] LAST = {1'b1, {(N-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            t <= LAST;
        end else if (adv) begin
            if (force_last)
                t <= LAST;
            else if (!hold)
                t <= {t[N-2:0], t[N-1]};
        end
    end

endmodule

// File: rtl/agc_timing_gen.sv
// Clock-phase / time-pulse generator with RT/WT/CT strobes, GOJAM restart
// sequencing, instruction/cycle step control, cycle scaler and overflow strobes.
module agc_timing_gen
    import agc_timing_gen_pkg::*;
#(
    parameter int NUM_TP      = DEF_NUM_TP,
    parameter int PHASES      = DEF_PHASES,
    parameter int SCALER_BITS = 8,
    parameter int WL_WIDTH    = 16
) (
    input  logic                   CLOCK,
    input  logic                   SIM_RST,
    input  logic [1:0]             MODE,
    input  logic                   MSTRTP,
    input  logic                   INST_END,
    input  logic                   RESTART,
    input  logic [WL_WIDTH-1:0]    WL,
    output logic [PHASES-1:0]      PHS,
    output logic [NUM_TP-1:0]      T,
    output logic                   RT,
    output logic                   WT,
    output logic                   CT,
    output logic                   TPEND,
    output logic                   STOP,
    output logic                   GOJAM,
    output logic [SCALER_BITS-1:0] SCALER,
    output logic                   OVF_n,
    output logic                   UNF_n
);

    localparam int            PW      = $clog2(PHASES);
    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
    localparam logic [PW-1:0] PH_WT   = PW'(PHASES / 2);

    logic [PW-1:0] ph;
    logic          adv, boundary, gojam_clr;
    logic          is_run, enter_hold, ring_hold, ring_force;
    logic          mstrt_q, mstrt_edge, go_req, primed;
    step_state_t   state;

    // Only the sign bits of the write bus matter here.
    logic unused_wl;
    assign unused_wl = ^WL[WL_WIDTH-3:0];

    assign adv        = (ph == PH_LAST);
    assign boundary   = adv && T[NUM_TP-1];
    assign TPEND      = boundary;
    assign gojam_clr  = boundary && !RESTART;
    assign is_run     = !(MODE == MODE_ISTEP || MODE == MODE_CSTEP);
    assign mstrt_edge = MSTRTP && !mstrt_q;
    assign PHS        = PHASES'(1) << ph;

    // Decision taken at a boundary: park on the last pulse, or let the ring go.
    always_comb begin
        enter_hold = 1'b0;
        case (state)
            S_HOLD:  enter_hold = !(is_run || go_req);
            default: enter_hold = (MODE == MODE_CSTEP) || (MODE == MODE_ISTEP && INST_END);
        endcase
    end

    assign ring_hold  = boundary && enter_hold;
    assign ring_force = GOJAM && !gojam_clr;

    agc_timing_gen_tp_ring #(.N(NUM_TP)) u_tp_ring (
        .clk       (CLOCK),
        .rst       (SIM_RST),
        .adv       (adv),
        .hold      (ring_hold),
        .force_last(ring_force),
        .t         (T)
    );

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            ph     <= '0;
            RT     <= 1'b0;
            WT     <= 1'b0;
            CT     <= 1'b0;
            GOJAM  <= 1'b1;
            SCALER <= '0;
            primed <= 1'b0;
            OVF_n  <= 1'b1;
            UNF_n  <= 1'b1;
        end else begin
            ph <= adv ? '0 : ph + 1'b1;
            RT <= (ph == '0);
            WT <= (ph == PH_WT);
            CT <= adv;
            if (RESTART)
                GOJAM <= 1'b1;
            else if (boundary)
                GOJAM <= 1'b0;
            // The stub cycle that ends the reset sequence is not a memory cycle.
            if (boundary) begin
                primed <= 1'b1;
                if (primed)
                    SCALER <= SCALER + 1'b1;
            end
            OVF_n <= !(CT && !WL[WL_WIDTH-1] &&  WL[WL_WIDTH-2]);
            UNF_n <= !(CT &&  WL[WL_WIDTH-1] && !WL[WL_WIDTH-2]);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state   <= S_RUN;
            STOP    <= 1'b0;
            go_req  <= 1'b0;
            mstrt_q <= 1'b0;
        end else begin
            mstrt_q <= MSTRTP;
            if (state == S_HOLD && mstrt_edge)
                go_req <= 1'b1;
            if (boundary) begin
                if (enter_hold) begin
                    state <= S_HOLD;
                    STOP  <= 1'b1;
                end else begin
                    if (is_run)
                        state <= S_RUN;
                    else if (state == S_HOLD)
                        state <= S_GO;
                    STOP   <= 1'b0;
                    go_req <= 1'b0;
                end
            end
        end
    end

endmodule
